// File: rtl/qpu_exu_meas_wbck_sched.sv
// Measurement write-back scheduler: buffers MCU results in a FIFO and drains them to the
// regfile measurement port. It also blocks FMR reads of qubits that have undelivered results.
// Optional same-cycle bypass when the FIFO is empty: define QPU_MEAS_WBCK_BYPASS_EN.
module qpu_exu_meas_wbck_sched #(
  parameter int QUBIT_NUM = 12,
  parameter int DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         mcu_i_valid,
  output logic                         mcu_i_ready,
  input  logic [QUBIT_NUM-1:0]         mcu_i_data,
  input  logic [QUBIT_NUM-1:0]         mcu_i_qlist,
  input  logic                         meas_pause,
  output logic                         rf_meas_wen,
  output logic [QUBIT_NUM-1:0]         rf_meas_data,
  output logic [QUBIT_NUM-1:0]         rf_meas_list,
  input  logic                         fmr_req,
  input  logic [QUBIT_NUM-1:0]         fmr_qlist,
  output logic                         fmr_grant,
  output logic [QUBIT_NUM-1:0]         pend_qlist,
  output logic [$clog2(DEPTH):0]       fifo_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]        CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0]        CNT_ZERO = {CW{1'b0}};
  localparam logic [AW-1:0]        PTR_ONE  = AW'(1'b1);
  localparam logic [QUBIT_NUM-1:0] Q_ZERO   = {QUBIT_NUM{1'b0}};

  logic [QUBIT_NUM-1:0] data_q  [DEPTH];
  logic [QUBIT_NUM-1:0] data_d  [DEPTH];
  logic [QUBIT_NUM-1:0] qlist_q [DEPTH];
  logic [QUBIT_NUM-1:0] qlist_d [DEPTH];
  logic [DEPTH-1:0]     vld_q, vld_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic                 ready_s;
  logic                 accept_s;
  logic                 has_q_s;
  logic                 pop_s;
  logic                 push_s;
  logic                 byp_s;
  logic [QUBIT_NUM-1:0] pend_s;
  logic [QUBIT_NUM-1:0] blk_s;

  // Handshake, drain and bypass decisions
  always_comb begin
    ready_s  = (cnt_q != CNT_FULL);
    accept_s = mcu_i_valid & ready_s;
    has_q_s  = (mcu_i_qlist != Q_ZERO);
    pop_s    = (cnt_q != CNT_ZERO) & ~meas_pause;
`ifdef QPU_MEAS_WBCK_BYPASS_EN
    byp_s    = accept_s & has_q_s & (cnt_q == CNT_ZERO) & ~meas_pause;
`else
    byp_s    = 1'b0;
`endif
    // Results with an empty qlist complete the handshake but are never stored.
    push_s   = accept_s & has_q_s & ~byp_s;
  end

  // Next-state for storage, pointers and occupancy
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      data_d[i]  = data_q[i];
      qlist_d[i] = qlist_q[i];
    end
    vld_d    = vld_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (pop_s) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_s) begin
      data_d[wr_ptr_q]  = mcu_i_data;
      qlist_d[wr_ptr_q] = mcu_i_qlist;
      vld_d[wr_ptr_q]   = 1'b1;
      wr_ptr_d          = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    cnt_d = cnt_q + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
  end

  // Pending-qubit mask over all undelivered entries
  always_comb begin
    pend_s = Q_ZERO;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i]) begin
        pend_s = pend_s | qlist_q[i];
      end else begin
        pend_s = pend_s;
      end
    end
  end

  // Regfile write port, FMR gating and status outputs
  always_comb begin
    mcu_i_ready = ready_s;
    fifo_cnt    = cnt_q;
    pend_qlist  = pend_s;
    rf_meas_wen = pop_s | byp_s;
    if (pop_s) begin
      rf_meas_data = data_q[rd_ptr_q];
      rf_meas_list = qlist_q[rd_ptr_q];
    end else if (byp_s) begin
      rf_meas_data = mcu_i_data;
      rf_meas_list = mcu_i_qlist;
    end else begin
      rf_meas_data = Q_ZERO;
      rf_meas_list = Q_ZERO;
    end
    // An incoming result blocks its qubits as well, since the regfile only sees stored results.
    blk_s     = pend_s | (accept_s ? mcu_i_qlist : Q_ZERO);
    fmr_grant = fmr_req & ((fmr_qlist & blk_s) == Q_ZERO);
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i]  <= Q_ZERO;
        qlist_q[i] <= Q_ZERO;
      end
      vld_q    <= {DEPTH{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      wr_ptr_q <= {AW{1'b0}};
      cnt_q    <= CNT_ZERO;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i]  <= data_d[i];
        qlist_q[i] <= qlist_d[i];
      end
      vld_q    <= vld_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_qpu_exu_meas_wbck_sched.sv
// Directed bench for qpu_exu_meas_wbck_sched (default build, bypass disabled).
module tb_qpu_exu_meas_wbck_sched;

  logic        clk;
  logic        rst_n;
  logic        mcu_i_valid;
  logic        mcu_i_ready;
  logic [11:0] mcu_i_data;
  logic [11:0] mcu_i_qlist;
  logic        meas_pause;
  logic        rf_meas_wen;
  logic [11:0] rf_meas_data;
  logic [11:0] rf_meas_list;
  logic        fmr_req;
  logic [11:0] fmr_qlist;
  logic        fmr_grant;
  logic [11:0] pend_qlist;
  logic [2:0]  fifo_cnt;

  int checks = 0;
  int errors = 0;

  qpu_exu_meas_wbck_sched #(.QUBIT_NUM(12), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .mcu_i_valid(mcu_i_valid), .mcu_i_ready(mcu_i_ready),
    .mcu_i_data(mcu_i_data), .mcu_i_qlist(mcu_i_qlist),
    .meas_pause(meas_pause),
    .rf_meas_wen(rf_meas_wen), .rf_meas_data(rf_meas_data), .rf_meas_list(rf_meas_list),
    .fmr_req(fmr_req), .fmr_qlist(fmr_qlist), .fmr_grant(fmr_grant),
    .pend_qlist(pend_qlist), .fifo_cnt(fifo_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          mcnt;
    int          n;
    logic        pz;
    logic        offer;
    logic [23:0] qd[$];
    logic [23:0] ent;

    rst_n = 1'b0; mcu_i_valid = 1'b0; mcu_i_data = 12'h000; mcu_i_qlist = 12'h000;
    meas_pause = 1'b0; fmr_req = 1'b0; fmr_qlist = 12'h000;
    #2;
    check("rst_cnt",   32'(fifo_cnt),     32'd0);
    check("rst_ready", 32'(mcu_i_ready),  32'd1);
    check("rst_wen",   32'(rf_meas_wen),  32'd0);
    check("rst_data",  32'(rf_meas_data), 32'h0);
    check("rst_list",  32'(rf_meas_list), 32'h0);
    check("rst_pend",  32'(pend_qlist),   32'h0);
    check("rst_grant", 32'(fmr_grant),    32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single result, latency 1
    mcu_i_valid = 1'b1; mcu_i_data = 12'h005; mcu_i_qlist = 12'h00F;
    fmr_req = 1'b1; fmr_qlist = 12'h001;
    #1;
    check("single_wen0", 32'(rf_meas_wen), 32'd0);
    check("grant_incoming_blk", 32'(fmr_grant), 32'd0);
    tick();
    mcu_i_valid = 1'b0;
    #1;
    check("single_wen1",  32'(rf_meas_wen),  32'd1);
    check("single_data1", 32'(rf_meas_data), 32'h005);
    check("single_list1", 32'(rf_meas_list), 32'h00F);
    check("single_cnt1",  32'(fifo_cnt),     32'd1);
    check("single_pend1", 32'(pend_qlist),   32'h00F);
    check("grant_head_blk", 32'(fmr_grant), 32'd0);
    fmr_qlist = 12'h010;
    #1;
    check("grant_disjoint", 32'(fmr_grant), 32'd1);
    tick();
    fmr_qlist = 12'h001;
    #1;
    check("single_wen2",  32'(rf_meas_wen),  32'd0);
    check("single_cnt2",  32'(fifo_cnt),     32'd0);
    check("single_pend2", 32'(pend_qlist),   32'h000);
    check("single_data2", 32'(rf_meas_data), 32'h000);
    check("grant_after",  32'(fmr_grant),    32'd1);
    fmr_req = 1'b0;

    // Zero qlist is dropped
    mcu_i_valid = 1'b1; mcu_i_data = 12'h3FF; mcu_i_qlist = 12'h000;
    #1;
    check("zq_ready", 32'(mcu_i_ready), 32'd1);
    tick();
    mcu_i_valid = 1'b0;
    #1;
    check("zq_cnt", 32'(fifo_cnt),    32'd0);
    check("zq_wen", 32'(rf_meas_wen), 32'd0);

    // Fill while paused, fifth push waits
    meas_pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mcu_i_valid = 1'b1; mcu_i_data = 12'h100 + 12'(i); mcu_i_qlist = 12'h001 << i;
      #1;
      check("full_ready_lo", 32'(mcu_i_ready), 32'd1);
      tick();
    end
    mcu_i_data = 12'h104; mcu_i_qlist = 12'h010;
    #1;
    check("full_ready", 32'(mcu_i_ready), 32'd0);
    check("full_cnt",   32'(fifo_cnt),    32'd4);
    check("full_wen",   32'(rf_meas_wen), 32'd0);
    check("full_pend",  32'(pend_qlist),  32'h00F);
    meas_pause = 1'b0;
    #1;
    check("drain0_ready", 32'(mcu_i_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("drain_wen",  32'(rf_meas_wen),  32'd1);
      check("drain_data", 32'(rf_meas_data), 32'h100 + 32'(i));
      check("drain_list", 32'(rf_meas_list), 32'h001 << i);
      tick();
      if (i == 0) check("drain1_ready", 32'(mcu_i_ready), 32'd1);
      if (i == 1) mcu_i_valid = 1'b0;
    end
    #1;
    check("drain_done_cnt", 32'(fifo_cnt),    32'd0);
    check("drain_done_wen", 32'(rf_meas_wen), 32'd0);

    // Wrap: 10 pushes with pauses against a small reference queue
    mcnt = 0; n = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      pz = ((cyc >= 1) && (cyc < 6)) || ((cyc % 4) == 3);
      offer = (n < 10);
      meas_pause = pz; mcu_i_valid = offer;
      mcu_i_data = 12'h200 + 12'(n); mcu_i_qlist = 12'(n + 1);
      #1;
      check("wrap_cnt",   32'(fifo_cnt),    32'(mcnt));
      check("wrap_ready", 32'(mcu_i_ready), 32'(mcnt != 4));
      check("wrap_wen",   32'(rf_meas_wen), 32'((mcnt != 0) && !pz));
      if ((mcnt != 0) && !pz) begin
        ent = qd.pop_front();
        check("wrap_data", 32'(rf_meas_data), 32'(ent[11:0]));
        check("wrap_list", 32'(rf_meas_list), 32'(ent[23:12]));
        mcnt--;
      end
      if (offer && (fifo_cnt != 3'd4) && ((mcnt + ((rf_meas_wen) ? 1 : 0)) != 4)) begin
        qd.push_back({mcu_i_qlist, mcu_i_data});
        n++;
        mcnt++;
      end
      tick();
    end
    mcu_i_valid = 1'b0; meas_pause = 1'b0;
    #1;
    check("wrap_all_pushed", 32'(n), 32'd10);
    check("wrap_empty", 32'(fifo_cnt), 32'd0);

    // FMR gating against a buffered entry
    meas_pause = 1'b1;
    mcu_i_valid = 1'b1; mcu_i_data = 12'h0AA; mcu_i_qlist = 12'h010;
    fmr_req = 1'b1; fmr_qlist = 12'h010;
    #1;
    check("fmr_in_blk", 32'(fmr_grant), 32'd0);
    fmr_qlist = 12'h001;
    #1;
    check("fmr_in_ok", 32'(fmr_grant), 32'd1);
    tick();
    mcu_i_valid = 1'b0; fmr_qlist = 12'h010;
    #1;
    check("fmr_buf_blk", 32'(fmr_grant),  32'd0);
    check("fmr_buf_pend", 32'(pend_qlist), 32'h010);
    fmr_qlist = 12'h000;
    #1;
    check("fmr_zero_ok", 32'(fmr_grant), 32'd1);
    fmr_qlist = 12'h010; meas_pause = 1'b0;
    #1;
    check("fmr_head_wen", 32'(rf_meas_wen), 32'd1);
    check("fmr_head_blk", 32'(fmr_grant),   32'd0);
    tick();
    #1;
    check("fmr_after_ok",   32'(fmr_grant),  32'd1);
    check("fmr_after_pend", 32'(pend_qlist), 32'h000);
    fmr_req = 1'b0;

    // Async reset with 3 buffered entries under pause
    meas_pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mcu_i_valid = 1'b1; mcu_i_data = 12'h300 + 12'(i); mcu_i_qlist = 12'h001 << i;
      tick();
    end
    mcu_i_valid = 1'b0;
    #1;
    check("ar_pre_cnt",  32'(fifo_cnt),   32'd3);
    check("ar_pre_pend", 32'(pend_qlist), 32'h007);
    check("ar_pre_ready", 32'(mcu_i_ready), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_cnt",   32'(fifo_cnt),     32'd0);
    check("ar_ready", 32'(mcu_i_ready),  32'd1);
    check("ar_pend",  32'(pend_qlist),   32'h000);
    check("ar_wen",   32'(rf_meas_wen),  32'd0);
    check("ar_data",  32'(rf_meas_data), 32'h000);
    check("ar_list",  32'(rf_meas_list), 32'h000);
    check("ar_grant", 32'(fmr_grant),    32'd0);
    meas_pause = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("ar_post_cnt",   32'(fifo_cnt),    32'd0);
    check("ar_post_ready", 32'(mcu_i_ready), 32'd1);
    check("ar_post_wen",   32'(rf_meas_wen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
